// File: rtl/eeprom_pkg.sv
// ============================================================================
// Module  : eeprom_pkg
// Brief   : Shared types and sizes for the EEPROM arbiter slice.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package eeprom_pkg;

  localparam int EEPROM_ADDR_W = 11;
  localparam int EEPROM_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_ACK = 2'd2,
    DONE     = 2'd3
  } state_t;

  typedef struct packed {
    logic                     we;
    logic [EEPROM_ADDR_W-1:0] addr;
    logic [EEPROM_DATA_W-1:0] wdata;
  } cmd_t;

  // One-hot port mask from a port index.
  function automatic logic [1:0] port_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

`default_nettype wire

// File: rtl/eeprom_rr_arb2.sv
// ============================================================================
// Module  : eeprom_rr_arb2
// Brief   : Two-input round-robin grant. The last-served pointer resets to
//           port 1 so port 0 wins the first contention; it updates whenever
//           a grant is issued.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module eeprom_rr_arb2 (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic [1:0] grant
);

  logic last_r;

  // Combinational grant: single requester wins, contention goes to the port not last served.
  always_comb begin
    grant = 2'b00;
    if (grant_en) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_r ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  // Last-served pointer, updated on every grant.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      last_r <= 1'b1;
    end else if (|grant) begin
      last_r <= grant[1];
    end
  end

endmodule

`default_nettype wire

// File: rtl/eeprom_arbiter.sv
// ============================================================================
// Module  : eeprom_arbiter
// Brief   : Two-port round-robin arbiter and sequencer in front of the I2C
//           EEPROM read/write engine. Optional command timeout is enabled
//           by defining EEPROM_ARB_TIMEOUT_EN.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module eeprom_arbiter
  import eeprom_pkg::*;
#(
  parameter logic [15:0] TIMEOUT = 16'd4000
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [1:0]               req_i,
  input  logic [1:0]               we_i,
  input  logic [EEPROM_ADDR_W-1:0] addr0_i,
  input  logic [EEPROM_ADDR_W-1:0] addr1_i,
  input  logic [EEPROM_DATA_W-1:0] wdata0_i,
  input  logic [EEPROM_DATA_W-1:0] wdata1_i,
  output logic [1:0]               done_o,
  output logic                     err_o,
  output logic [EEPROM_DATA_W-1:0] rdata_o,
  output logic                     busy_o,
  output logic                     WR,
  output logic                     RD,
  output logic [EEPROM_ADDR_W-1:0] ADDR,
  output logic [EEPROM_DATA_W-1:0] eng_wdata_o,
  output logic                     eng_wdata_oe,
  input  logic [EEPROM_DATA_W-1:0] eng_rdata_i,
  input  logic                     ACK
);

  state_t     state, state_nx;
  cmd_t       cmd_r;
  logic       winner_r;
  logic [1:0] grant;
  logic       timeout_hit;
  logic       err_flag;

  eeprom_rr_arb2 u_arb (
    .CLK      (CLK),
    .RESET    (RESET),
    .req      (req_i),
    .grant_en (state == IDLE),
    .grant    (grant)
  );

`ifdef EEPROM_ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic        err_r;

  // Expiry fires on the TIMEOUT-th WAIT_ACK cycle, so DONE lands exactly
  // TIMEOUT cycles after WAIT_ACK entry.
  assign timeout_hit = (state == WAIT_ACK) && (tmo_cnt == TIMEOUT - 16'd1);
  assign err_flag    = err_r;

  // Cycle counter: zeroed in ISSUE, counts while waiting for ACK; err flag records a timeout exit.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      tmo_cnt <= 16'd0;
      err_r   <= 1'b0;
    end else begin
      if (state == ISSUE) begin
        tmo_cnt <= 16'd0;
        err_r   <= 1'b0;
      end else if (state == WAIT_ACK) begin
        tmo_cnt <= tmo_cnt + 16'd1;
        if (timeout_hit && !ACK) err_r <= 1'b1;
      end
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout_hit    = 1'b0;
  assign err_flag       = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic; DONE never grants, leaving a one-cycle gap between commands.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (|grant) state_nx = ISSUE;
      ISSUE:    state_nx = WAIT_ACK;
      WAIT_ACK: if (ACK || timeout_hit) state_nx = DONE;
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Command register and winner, latched at grant.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cmd_r    <= '0;
      winner_r <= 1'b0;
    end else if (|grant) begin
      winner_r    <= grant[1];
      cmd_r.we    <= grant[1] ? we_i[1]  : we_i[0];
      cmd_r.addr  <= grant[1] ? addr1_i  : addr0_i;
      cmd_r.wdata <= grant[1] ? wdata1_i : wdata0_i;
    end
  end

  // Read data captured in the ACK cycle of a read; held until the next read completes.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rdata_o <= '0;
    end else if (state == WAIT_ACK && ACK && !cmd_r.we) begin
      rdata_o <= eng_rdata_i;
    end
  end

  // Engine command and requester status outputs decoded from state and command register.
  always_comb begin
    WR           = 1'b0;
    RD           = 1'b0;
    eng_wdata_oe = 1'b0;
    eng_wdata_o  = '0;
    ADDR         = cmd_r.addr;
    done_o       = 2'b00;
    err_o        = 1'b0;
    busy_o       = (state != IDLE);
    if (state == ISSUE || state == WAIT_ACK) begin
      WR           = cmd_r.we;
      RD           = ~cmd_r.we;
      eng_wdata_oe = cmd_r.we;
      eng_wdata_o  = cmd_r.we ? cmd_r.wdata : '0;
    end
    if (state == DONE) begin
      done_o = port_onehot(winner_r);
      err_o  = err_flag;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_eeprom_arbiter.sv
// ============================================================================
// Module  : tb_eeprom_arbiter
// Brief   : Self-checking bench for eeprom_arbiter: transaction-level model
//           compared every cycle, plus directed literal checks. Timeout
//           branch follows EEPROM_ARB_TIMEOUT_EN.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_eeprom_arbiter;

  localparam logic [15:0] TO = 16'd20;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [1:0]  req_i = 2'b00;
  logic [1:0]  we_i = 2'b00;
  logic [10:0] addr0_i = '0, addr1_i = '0;
  logic [7:0]  wdata0_i = '0, wdata1_i = '0;
  logic [1:0]  done_o;
  logic        err_o;
  logic [7:0]  rdata_o;
  logic        busy_o;
  logic        WR, RD;
  logic [10:0] ADDR;
  logic [7:0]  eng_wdata_o;
  logic        eng_wdata_oe;
  logic [7:0]  eng_rdata_i = 8'hEE;
  logic        ACK = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  eeprom_arbiter #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .RESET(RESET), .req_i(req_i), .we_i(we_i),
    .addr0_i(addr0_i), .addr1_i(addr1_i), .wdata0_i(wdata0_i), .wdata1_i(wdata1_i),
    .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o), .busy_o(busy_o),
    .WR(WR), .RD(RD), .ADDR(ADDR), .eng_wdata_o(eng_wdata_o), .eng_wdata_oe(eng_wdata_oe),
    .eng_rdata_i(eng_rdata_i), .ACK(ACK)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // Tracks one outstanding command: its age in cycles since grant, whether the
  // engine command is still on, and whether this cycle is the completion cycle.
  logic        m_valid = 1'b0;
  logic        m_busy, m_cmd, m_done, m_err, m_last, m_port, m_we;
  logic [10:0] m_addr;
  logic [7:0]  m_wdata, m_rdata;
  int          m_age;

  always @(posedge CLK) begin
    if (RESET) begin
      m_valid <= 1'b1; m_busy <= 1'b0; m_cmd <= 1'b0; m_done <= 1'b0; m_err <= 1'b0;
      m_last <= 1'b1; m_port <= 1'b0; m_we <= 1'b0; m_addr <= '0; m_wdata <= '0;
      m_rdata <= '0; m_age <= 0;
    end else if (m_done) begin
      m_done <= 1'b0; m_busy <= 1'b0; m_err <= 1'b0;
    end else if (m_cmd) begin
      m_age <= m_age + 1;
      if (m_age >= 2 && ACK) begin
        m_cmd <= 1'b0; m_done <= 1'b1;
        if (!m_we) m_rdata <= eng_rdata_i;
      end
`ifdef EEPROM_ARB_TIMEOUT_EN
      else if (m_age - 1 == int'(TO)) begin
        m_cmd <= 1'b0; m_done <= 1'b1; m_err <= 1'b1;
      end
`endif
    end else if (req_i != 2'b00) begin
      logic p;
      p = (req_i == 2'b11) ? ~m_last : req_i[1];
      m_last <= p; m_port <= p; m_busy <= 1'b1; m_cmd <= 1'b1; m_age <= 1;
      m_we    <= p ? we_i[1] : we_i[0];
      m_addr  <= p ? addr1_i : addr0_i;
      m_wdata <= p ? wdata1_i : wdata0_i;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge CLK) begin
    if (m_valid) begin
      logic [1:0] exp_done;
      exp_done = m_done ? (m_port ? 2'b10 : 2'b01) : 2'b00;
      check("model_outputs",
            {30'd0, WR, RD, ADDR, eng_wdata_o, eng_wdata_oe, done_o, err_o, rdata_o, busy_o},
            {30'd0, m_cmd & m_we, m_cmd & ~m_we, m_addr, (m_cmd & m_we) ? m_wdata : 8'h00,
             m_cmd & m_we, exp_done, m_done & m_err, m_rdata, m_busy});
      check("wr_rd_exclusive", {63'd0, WR & RD}, 64'd0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_cmd(output int n);
    n = 0;
    while (!(WR || RD) && n < 64) begin @(negedge CLK); n++; end
    check("cmd_seen", {63'd0, WR | RD}, 64'd1);
  endtask

  // Waits for the engine command, ACKs after dly more cycles, returns
  // cycles from the calling negedge to the done cycle.
  task automatic serve(input int dly, input logic [7:0] rd, output int lat);
    int n;
    wait_cmd(n);
    repeat (dly) begin @(negedge CLK); n++; end
    ACK = 1'b1; eng_rdata_i = rd;
    @(negedge CLK); n++;
    ACK = 1'b0; eng_rdata_i = 8'hEE;
    check("done_seen", {63'd0, |done_o}, 64'd1);
    lat = n;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n;
    logic [3:0] seq;

    // Reset state
    repeat (3) @(negedge CLK);
    check("reset_outputs", {WR, RD, ADDR, eng_wdata_o, eng_wdata_oe, done_o, err_o, rdata_o, busy_o}, 34'd0);
    RESET = 1'b0;

    // Single write, ACK 10 cycles after WR rises
    @(negedge CLK);
    req_i = 2'b01; we_i = 2'b01; addr0_i = 11'h155; wdata0_i = 8'hA5;
    wait_cmd(n);
    repeat (10) begin
      @(negedge CLK);
      check("wr_stable", {WR, ADDR, eng_wdata_o, eng_wdata_oe}, {1'b1, 11'h155, 8'hA5, 1'b1});
    end
    ACK = 1'b1;
    @(negedge CLK);
    ACK = 1'b0;
    check("wr_done", {done_o, err_o, WR}, {2'b01, 1'b0, 1'b0});
    req_i = 2'b00;

    // Single read on port 1, minimum latency
    @(negedge CLK);
    req_i = 2'b10; we_i = 2'b00; addr1_i = 11'h7FF;
    serve(1, 8'h3C, lat);
    check("rd_latency", lat, 3);
    check("rd_result", {done_o, rdata_o}, {2'b10, 8'h3C});
    req_i = 2'b00;

    // Contention: both ports request continuously
    @(negedge CLK);
    req_i = 2'b11; we_i = 2'b00; addr0_i = 11'h010; addr1_i = 11'h020;
    seq = 4'b0000;
    for (int t = 0; t < 4; t++) begin
      serve(1, 8'h40 + 8'(t), lat);
      seq = {seq[2:0], done_o[1]};
      check("cont_spacing", lat, (t == 0) ? 3 : 4);
      if (t == 3) req_i = 2'b00;
    end
    check("cont_order", seq, 4'b0101);
    check("cont_rdata", rdata_o, 8'h43);

    // Reset during WAIT_ACK, then normal service of the held request
    @(negedge CLK);
    req_i = 2'b01; we_i = 2'b01; addr0_i = 11'h2AA; wdata0_i = 8'h5A;
    wait_cmd(n);
    repeat (3) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    check("rst_mid", {WR, RD, busy_o, done_o}, 5'd0);
    RESET = 1'b0;
    serve(2, 8'h00, lat);
    check("rst_after_done", done_o, 2'b01);
    req_i = 2'b00;

    // Stray ACK in IDLE, ACK during ISSUE, request dropped mid-transaction
    @(negedge CLK);
    ACK = 1'b1;
    @(negedge CLK);
    ACK = 1'b0;
    check("stray_ack_idle", {busy_o, done_o}, 3'd0);
    req_i = 2'b10; we_i = 2'b10; addr1_i = 11'h0F0; wdata1_i = 8'hC3;
    wait_cmd(n);
    ACK = 1'b1; req_i = 2'b00;
    @(negedge CLK);
    ACK = 1'b0;
    check("ack_in_issue_ignored", {WR, done_o}, {1'b1, 2'b00});
    serve(2, 8'h00, lat);
    check("drop_req_done", {done_o, err_o}, {2'b10, 1'b0});

    // Timeout behaviour: the engine never acknowledges
    @(negedge CLK);
    req_i = 2'b01; we_i = 2'b00; addr0_i = 11'h123;
    wait_cmd(n);
    @(negedge CLK);
`ifdef EEPROM_ARB_TIMEOUT_EN
    n = 0;
    while (done_o == 2'b00 && n < 100) begin @(negedge CLK); n++; end
    check("timeout_cycles", n, 20);
    // rdata_o was cleared by the mid-transaction reset and must stay unchanged
    check("timeout_result", {done_o, err_o, RD, rdata_o}, {2'b01, 1'b1, 1'b0, 8'h00});
    req_i = 2'b00;
    @(negedge CLK);
`else
    repeat (1000) @(negedge CLK);
    check("no_timeout_hold", {RD, done_o, busy_o}, {1'b1, 2'b00, 1'b1});
    req_i = 2'b00;
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
`endif
    repeat (2) @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/eeprom_arbiter.md
# eeprom_arbiter

Two-port arbiter and sequencer in front of the I2C EEPROM read/write engine (11-bit address, 8-bit data, WR/RD request levels, one-cycle ACK on completion). It accepts single-byte read/write commands from two independent requesters, grants them round-robin, and drives the engine's command inputs until ACK. It returns read data and a completion pulse to the winning port. It sits between system-side clients (e.g. a config loader and a host register bridge) and the engine.

## Interface
- TIMEOUT, 16'd4000: CLK cycles allowed between command issue and engine ACK; active only with the timeout feature.
- CLK  in  1  clock; all logic on posedge.
- RESET  in  1  reset, synchronous, active-high.
- req_i  in  2  per-port request level; held high until that port's done_o.
- we_i  in  2  per-port direction: 1 = write, 0 = read.
- addr0_i, addr1_i  in  11 each  per-port EEPROM byte address.
- wdata0_i, wdata1_i  in  8 each  per-port write data.
- done_o  out  2  one-cycle completion pulse, one-hot.
- err_o  out  1  valid with done_o: 1 = aborted by timeout.
- rdata_o  out  8  read byte, valid with done_o after a read, held until the next done.
- busy_o  out  1  high from grant until return to IDLE.
- WR, RD  out  1 each  engine command levels; never both high.
- ADDR  out  11  engine address.
- eng_wdata_o  out  8  byte for the engine data bus.
- eng_wdata_oe  out  1  drive enable for the engine data bus (tristate is resolved at top level).
- eng_rdata_i  in  8  engine data bus readback.
- ACK  in  1  engine completion pulse.

## Operation
- FSM states: IDLE, ISSUE, WAIT_ACK, DONE.
- IDLE:
  - If any req_i bit is high, pick the winner, latch we/addr/wdata into the command register, and go to ISSUE.
- Round-robin:
  - A last-served pointer resets to 1, so port 0 wins the first contention.
  - If only one port requests, that port wins.
  - If both request, the port not last served wins.
  - The pointer updates on grant.
- ISSUE:
  - Assert WR (we=1) or RD (we=0) and drive ADDR.
  - For writes, drive eng_wdata_o with eng_wdata_oe=1.
  - Go to WAIT_ACK.
- WAIT_ACK:
  - Hold WR/RD, ADDR and data stable.
  - When ACK=1: deassert WR/RD/oe in the next cycle; for reads, capture eng_rdata_i into rdata_o in the ACK cycle; go to DONE.
- DONE:
  - Pulse done_o[winner] for one cycle with err_o, then return to IDLE.
  - A request is not granted in DONE. This gives a mandatory one-cycle gap between engine commands.
- Requester rules:
  - A req_i falling mid-transaction does not abort it; done_o still pulses.
  - After done, the port must drop req_i for at least one cycle or it is re-arbitrated as a new request.
- ACK outside WAIT_ACK is ignored.
- Reset values:
  - State IDLE.
  - WR=RD=0, ADDR=0, eng_wdata_o=0, eng_wdata_oe=0.
  - done_o=0, err_o=0, rdata_o=0, busy_o=0.
- Reset mid-transaction forces IDLE immediately. No done_o is issued for the dropped command.

## Timing
- Request seen in IDLE at cycle N: winner latched at N, WR/RD high from N+1 (ISSUE), held through WAIT_ACK.
- ACK at cycle M: WR/RD low at M+1, done_o at M+1 (DONE), IDLE at M+2.
- Earliest next grant at M+2, with WR/RD high again at M+3.
- Minimum request-to-done latency: 3 cycles, when ACK arrives the first cycle in WAIT_ACK.
- busy_o is high from N+1 through M+1 inclusive.

## Configuration
- EEPROM_ARB_TIMEOUT_EN defined:
  - A 16-bit counter clears on entry to ISSUE and increments in WAIT_ACK.
  - When it reaches TIMEOUT without ACK, drop WR/RD/oe and go to DONE with err_o=1; rdata_o is unchanged.
  - ACK in the same cycle as expiry counts as success (err_o=0).
- Not defined: no counter; WAIT_ACK waits indefinitely and err_o is tied 0.

## Structure
- Shared package eeprom_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT_ACK, DONE);
  - a command struct {we, addr[10:0], wdata[7:0]};
  - EEPROM_ADDR_W=11 and EEPROM_DATA_W=8.
- One sub-module: eeprom_rr_arb2, a 2-input round-robin grant with pointer register and a grant-enable input.

## Test plan
- Single write: port 0 requests we=1, addr=11'h155, wdata=8'hA5; ACK 10 cycles after WR rises -> WR/ADDR/eng_wdata_o stable throughout, done_o=2'b01, err_o=0.
- Single read: port 1 requests a read of 11'h7FF; engine returns 8'h3C with ACK -> rdata_o=8'h3C with done_o=2'b10; RD and WR never both high.
- Contention: both ports request continuously for 4 transactions -> grants alternate 0,1,0,1 with a one-cycle idle gap between commands.
- Reset mid-transaction: RESET asserted during WAIT_ACK -> next cycle WR=RD=0, busy_o=0, no done_o; the port's next request is served normally.
- Timeout (macro on, TIMEOUT=20): never send ACK -> WR drops and done_o pulses with err_o=1 exactly 20 cycles after WAIT_ACK entry; with the macro off, WR stays high for 1000 cycles.
- Stray ACK in IDLE and req_i dropped mid-transaction -> no state change; the in-flight command still completes and done_o pulses.
